// File: rtl/io_switch_pkg.sv
// Shared definitions for the 4x4 switch route arbiter: source select codes,
// port count and the scheduler state encoding.
package io_switch_pkg;

  localparam int NUM_PORTS = 4;

  localparam logic [2:0] SRC_CODE_0    = 3'b001;
  localparam logic [2:0] SRC_CODE_1    = 3'b010;
  localparam logic [2:0] SRC_CODE_2    = 3'b100;
  localparam logic [2:0] SRC_CODE_3    = 3'b111;
  localparam logic [2:0] SRC_CODE_NONE = 3'b000;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CONNECT,
    ST_SETTLE,
    ST_DISCONNECT
  } state_t;

  function automatic logic [2:0] src_code(input logic [1:0] src);
    case (src)
      2'd0:    src_code = SRC_CODE_0;
      2'd1:    src_code = SRC_CODE_1;
      2'd2:    src_code = SRC_CODE_2;
      default: src_code = SRC_CODE_3;
    endcase
  endfunction

endpackage

// File: rtl/io_switch_route_arbiter_rr_arb4.sv
// Four-way round-robin picker: returns the first requester at or after ptr,
// as both a one-hot vector and an index.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] onehot,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    // Walk backwards so the candidate closest to ptr is the last one written.
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) idx = cand;
    end
    onehot = any ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/io_switch_route_arbiter.sv
// Round-robin route scheduler for the 4x4 streaming switch: programs routes,
// grants after settle, tears routes down on end of packet or watchdog expiry.
module io_switch_route_arbiter
  import io_switch_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_valid,
  input  logic [7:0] req_dest,
  input  logic [3:0] pkt_done,
  output logic [3:0] grant,
  output logic [1:0] ctrl_addr,
  output logic       ctrl_wr_en,
  output logic [2:0] ctrl_wr_data,
  output logic       init_done,
  output logic       timeout_err
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX      = WD_W'(TIMEOUT_CYCLES - 1);
  localparam bit              WD_EN       = (TIMEOUT_CYCLES != 0);

  state_t                 state_reg;
  logic [1:0]             idx_reg;
  logic                   init_done_reg;
  logic                   timeout_err_reg;
  logic [3:0]             grant_reg;
  logic [3:0]             pending_reg;
  logic [3:0]             rel_flag_reg;
  logic [3:0]             owner_valid_reg;
  logic [3:0][1:0]        owner_idx_reg;
  logic [3:0][1:0]        rr_ptr_reg;
  logic [1:0]             out_ptr_reg;
  logic [1:0]             sel_o_reg;
  logic [1:0]             sel_i_reg;
  logic [SC_W-1:0]        settle_cnt_reg;
  logic [3:0][WD_W-1:0]   wd_cnt_reg;
  logic [1:0]             ctrl_addr_reg;
  logic                   ctrl_wr_en_reg;
  logic [2:0]             ctrl_wr_data_reg;

  logic [3:0][3:0] elig;
  logic [3:0][3:0] in_onehot;
  logic [3:0][1:0] in_idx;
  logic [3:0]      in_any;
  logic [3:0]      out_onehot;
  logic [1:0]      out_idx;
  logic            out_any;
  logic [3:0]      pick_in_onehot;
  logic [1:0]      pick_in_idx;
  logic [3:0]      owner_active;
  logic [3:0]      rel_done;
  logic [3:0]      rel_wd;
  logic [1:0]      rel_low_idx;

  // elig[o][i]: input i may be connected to output o right now.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        elig[o][i] = req_valid[i] & ~grant_reg[i] & ~pending_reg[i] &
                     ~owner_valid_reg[o] & (req_dest[2*i +: 2] == 2'(o));
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in_arb
      rr_arb4 u_in_arb (
        .req    (elig[gi]),
        .ptr    (rr_ptr_reg[gi]),
        .onehot (in_onehot[gi]),
        .idx    (in_idx[gi]),
        .any    (in_any[gi])
      );
    end
  endgenerate

  rr_arb4 u_out_arb (
    .req    (in_any),
    .ptr    (out_ptr_reg),
    .onehot (out_onehot),
    .idx    (out_idx),
    .any    (out_any)
  );

  always_comb begin
    pick_in_onehot = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (out_onehot[o]) pick_in_onehot = in_onehot[o];
    end
    pick_in_idx = in_idx[out_idx];
  end

  // An output is active while its owner still holds grant; once released it
  // only waits for its disconnect write.
  always_comb begin
    rel_low_idx = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      owner_active[o] = owner_valid_reg[o] & grant_reg[owner_idx_reg[o]];
      rel_done[o]     = owner_active[o] & pkt_done[owner_idx_reg[o]];
      rel_wd[o]       = owner_active[o] & WD_EN & ~rel_done[o] &
                        (wd_cnt_reg[o] == WD_MAX);
    end
    for (int o = NUM_PORTS - 1; o >= 0; o--) begin
      if (rel_flag_reg[o]) rel_low_idx = 2'(o);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_INIT;
      idx_reg          <= '0;
      init_done_reg    <= 1'b0;
      timeout_err_reg  <= 1'b0;
      grant_reg        <= '0;
      pending_reg      <= '0;
      rel_flag_reg     <= '0;
      owner_valid_reg  <= '0;
      owner_idx_reg    <= '0;
      rr_ptr_reg       <= '0;
      out_ptr_reg      <= '0;
      sel_o_reg        <= '0;
      sel_i_reg        <= '0;
      settle_cnt_reg   <= '0;
      wd_cnt_reg       <= '0;
      ctrl_addr_reg    <= '0;
      ctrl_wr_en_reg   <= 1'b0;
      ctrl_wr_data_reg <= '0;
    end else begin
      ctrl_wr_en_reg <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (rel_done[o] || rel_wd[o]) begin
          rel_flag_reg[o]            <= 1'b1;
          grant_reg[owner_idx_reg[o]] <= 1'b0;
        end
        if (owner_active[o]) wd_cnt_reg[o] <= wd_cnt_reg[o] + 1'b1;
      end
      if (|rel_wd) timeout_err_reg <= 1'b1;

      case (state_reg)
        ST_INIT: begin
          ctrl_wr_en_reg   <= 1'b1;
          ctrl_addr_reg    <= idx_reg;
          ctrl_wr_data_reg <= SRC_CODE_NONE;
          idx_reg          <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            init_done_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (|rel_flag_reg) begin
            sel_o_reg <= rel_low_idx;
            state_reg <= ST_DISCONNECT;
          end else if (out_any) begin
            sel_o_reg   <= out_idx;
            sel_i_reg   <= pick_in_idx;
            pending_reg <= pending_reg | pick_in_onehot;
            state_reg   <= ST_CONNECT;
          end
        end
        ST_CONNECT: begin
          ctrl_wr_en_reg   <= 1'b1;
          ctrl_addr_reg    <= sel_o_reg;
          ctrl_wr_data_reg <= src_code(sel_i_reg);
          settle_cnt_reg   <= SETTLE_LOAD;
          out_ptr_reg      <= sel_o_reg + 2'd1;
          state_reg        <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == '0) begin
            owner_valid_reg[sel_o_reg] <= 1'b1;
            owner_idx_reg[sel_o_reg]   <= sel_i_reg;
            grant_reg[sel_i_reg]       <= 1'b1;
            pending_reg[sel_i_reg]     <= 1'b0;
            wd_cnt_reg[sel_o_reg]      <= '0;
            state_reg                  <= ST_IDLE;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - 1'b1;
          end
        end
        ST_DISCONNECT: begin
          ctrl_wr_en_reg             <= 1'b1;
          ctrl_addr_reg              <= sel_o_reg;
          ctrl_wr_data_reg           <= SRC_CODE_NONE;
          owner_valid_reg[sel_o_reg] <= 1'b0;
          rel_flag_reg[sel_o_reg]    <= 1'b0;
          rr_ptr_reg[sel_o_reg]      <= owner_idx_reg[sel_o_reg] + 2'd1;
          state_reg                  <= ST_IDLE;
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign grant        = grant_reg;
  assign ctrl_addr    = ctrl_addr_reg;
  assign ctrl_wr_en   = ctrl_wr_en_reg;
  assign ctrl_wr_data = ctrl_wr_data_reg;
  assign init_done    = init_done_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_io_switch_route_arbiter.sv
// Directed bench for the route arbiter: init clear, connect latency, round
// robin, serialised connects/disconnects, watchdog and mid-operation reset.
module tb_io_switch_route_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_dest;
  logic [3:0] pkt_done;
  logic [3:0] grant;
  logic [1:0] ctrl_addr;
  logic       ctrl_wr_en;
  logic [2:0] ctrl_wr_data;
  logic       init_done;
  logic       timeout_err;

  int n_vec  = 0;
  int n_miss = 0;
  int took;
  int held;

  io_switch_route_arbiter #(
    .SETTLE_CYCLES  (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_dest     (req_dest),
    .pkt_done     (pkt_done),
    .grant        (grant),
    .ctrl_addr    (ctrl_addr),
    .ctrl_wr_en   (ctrl_wr_en),
    .ctrl_wr_data (ctrl_wr_data),
    .init_done    (init_done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one visible routing write as {wr_en, addr, data}.
  task automatic chk_wr(input string tag, input logic [1:0] addr, input logic [2:0] data);
    chk(tag, 32'({ctrl_wr_en, ctrl_addr, ctrl_wr_data}), 32'({1'b1, addr, data}));
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp, input int budget,
                            output int n);
    n = 0;
    while (grant !== exp && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(grant), 32'(exp));
  endtask

  task automatic chk_init_seq(input string tag);
    for (int a = 0; a < 4; a++) begin
      tick();
      chk_wr($sformatf("%s_wr%0d", tag, a), 2'(a), 3'b000);
      if (a < 3) chk($sformatf("%s_done_lo%0d", tag, a), 32'(init_done), 0);
    end
    chk({tag, "_done_hi"}, 32'(init_done), 1);
    chk({tag, "_grant"}, 32'(grant), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_dest = '0; pkt_done = '0;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_wr_en", 32'(ctrl_wr_en), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    rst = 1'b0;
    chk_init_seq("init");
    tick();
    chk("idle_wr_en", 32'(ctrl_wr_en), 0);

    // single request: input 0 -> output 2, grant four cycles later
    req_dest = 8'h02; req_valid = 4'b0001;
    tick(); chk("t2_grant_c1", 32'(grant), 0);
    tick(); chk_wr("t2_connect", 2'd2, 3'b001);
    tick(); chk("t2_grant_c3", 32'(grant), 0);
    tick(); chk("t2_grant_c4", 32'(grant), 32'h1);
    req_valid = '0; pkt_done = 4'b0001;
    tick(); pkt_done = '0; chk("t2_release", 32'(grant), 0);
    tick();
    tick(); chk_wr("t2_disconnect", 2'd2, 3'b000);

    // inputs 1 and 3 contend for output 0
    req_dest = 8'h00; req_valid = 4'b1010;
    wait_grant("t3_grant_in1", 4'b0010, 10, took);
    chk("t3_latency", 32'(took), 4);
    pkt_done = 4'b0010;
    tick(); pkt_done = '0; chk("t3_release_in1", 32'(grant), 0);
    wait_grant("t3_grant_in3", 4'b1000, 20, took);
    chk("t3_rr_latency", 32'(took), 6);
    req_valid = '0; pkt_done = 4'b1000;
    tick(); pkt_done = '0;
    tick();
    tick(); chk_wr("t3_disconnect", 2'd0, 3'b000);

    // input 0 -> output 1, input 2 -> output 3 in the same cycle
    req_dest = 8'h31; req_valid = 4'b0101;
    tick(); tick(); chk_wr("t4_conn_out1", 2'd1, 3'b001);
    tick(); tick(); chk("t4_grant_first", 32'(grant), 32'h1);
    tick(); tick(); chk_wr("t4_conn_out3", 2'd3, 3'b100);
    tick(); tick(); chk("t4_grant_both", 32'(grant), 32'h5);
    req_valid = '0; pkt_done = 4'b0101;
    tick(); pkt_done = '0; chk("t4_release_both", 32'(grant), 0);
    tick();
    tick(); chk_wr("t4_disc_out1", 2'd1, 3'b000);
    tick();
    tick(); chk_wr("t4_disc_out3", 2'd3, 3'b000);

    // watchdog: input 2 -> output 2 held with no pkt_done
    chk("t5_err_pre", 32'(timeout_err), 0);
    req_dest = 8'h20; req_valid = 4'b0100;
    wait_grant("t5_grant", 4'b0100, 10, took);
    req_valid = '0;
    held = 0;
    while (grant[2] && held < 40) begin
      tick();
      held++;
    end
    chk("t5_hold_cycles", 32'(held), 16);
    chk("t5_timeout_err", 32'(timeout_err), 1);
    chk("t5_grant_dropped", 32'(grant), 0);
    tick();
    tick(); chk_wr("t5_disconnect", 2'd2, 3'b000);

    // reset while input 1 -> output 3 is settling
    req_dest = 8'h0C; req_valid = 4'b0010;
    tick(); tick();
    rst = 1'b1; req_valid = '0;
    tick();
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_timeout_err", 32'(timeout_err), 0);
    chk("t6_rst_init_done", 32'(init_done), 0);
    chk("t6_rst_wr_en", 32'(ctrl_wr_en), 0);
    tick();
    rst = 1'b0;
    chk_init_seq("t6_init");
    for (int k = 0; k < 6; k++) tick();
    chk("t6_no_stale_grant", 32'(grant), 0);
    req_valid = 4'b0010;
    wait_grant("t6_regrant", 4'b0010, 10, took);
    chk("t6_regrant_latency", 32'(took), 4);
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
